// File: rtl/systolic_pkg.sv
// Shared types and helpers for the double-buffered weight-stationary systolic array.
package systolic_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 64;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2
  } ld_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/systolic_array_db_pe_cell.sv
// One MAC processing element: two weight banks (active/shadow), activation passes right,
// partial sum passes down, shadow bank shifts down during a weight load.
module pe_cell
  import systolic_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          bank_sel,
  input  logic          w_shift,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] w_in,
  input  logic [AW-1:0] ps_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] w_out,
  output logic [AW-1:0] ps_out
);

  logic [DW-1:0] a_q, a_d, w0_q, w0_d, w1_q, w1_d, w_act;
  logic [AW-1:0] ps_q, ps_d;
  logic signed [2*DW-1:0] prod;

  always_comb begin
    w_act = bank_sel ? w1_q : w0_q;
    prod  = $signed(a_in) * $signed(w_act);
    a_d   = a_in;
    ps_d  = ps_in + AW'(prod);
    w0_d  = w0_q;
    w1_d  = w1_q;
    // only the bank not selected for compute is ever written
    if (w_shift) begin
      if (bank_sel) w0_d = w_in;
      else          w1_d = w_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      ps_q <= '0;
      w0_q <= '0;
      w1_q <= '0;
    end else if (en) begin
      a_q  <= a_d;
      ps_q <= ps_d;
      w0_q <= w0_d;
      w1_q <= w1_d;
    end
  end

  assign a_out  = a_q;
  assign ps_out = ps_q;
  assign w_out  = bank_sel ? w0_q : w1_q;

endmodule

// File: rtl/systolic_array_db.sv
// Weight-stationary systolic MAC array with double-buffered weights, input skew,
// output de-skew, weight-load FSM, bank swap control and in-flight tracking.
module systolic_array_db
  import systolic_pkg::*;
#(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               EN,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [COLS*DW-1:0] w_row,
  input  logic               swap_req,
  output logic               swap_done,
  input  logic               act_valid,
  output logic               act_ready,
  input  logic [ROWS*DW-1:0] act_in,
  output logic               sum_valid,
  output logic [COLS*AW-1:0] sum_out,
  output logic               bank_sel,
  output logic               busy
);

  localparam int STAGES = ROWS + COLS;
  // a vector retires the cycle after its sum_valid, so ROWS+COLS+1 can be counted at once
  localparam int CNT_W  = clog2(STAGES + 2);
  localparam int BW     = clog2(ROWS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(ROWS - 1);

  ld_state_e          ld_q, ld_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic               pend_q, pend_d;
  logic               bank_q, bank_d;
  logic               swap_done_q, swap_done_d;
  logic               sum_valid_q, sum_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STAGES-1:0]  vld_pipe_q, vld_pipe_d;
  logic [COLS*AW-1:0] sum_q, sum_d;
  logic               accept, beat, do_swap;

  logic [ROWS-1:0][COLS:0][DW-1:0]   a_h;
  logic [ROWS:0][COLS-1:0][AW-1:0]   ps_v;
  logic [ROWS:0][COLS-1:0][DW-1:0]   w_v;
  logic [COLS-1:0][AW-1:0]           ds_out;
  logic [ROWS-1:0][DW-1:0]           a_edge_unused;
  logic [COLS-1:0][DW-1:0]           w_edge_unused;

  always_comb begin
    accept  = act_valid & ~pend_q;
    beat    = w_valid & (ld_q != FULL);
    do_swap = pend_q & (cnt_q == '0) & (ld_q == FULL);

    ld_d   = ld_q;
    beat_d = beat_q;
    if (do_swap) begin
      ld_d = EMPTY;
    end else if (beat) begin
      if (beat_q == LAST_BEAT) begin
        ld_d   = FULL;
        beat_d = '0;
      end else begin
        ld_d   = LOADING;
        beat_d = beat_q + BW'(1);
      end
    end

    pend_d      = do_swap ? 1'b0 : (pend_q | swap_req);
    bank_d      = bank_q ^ do_swap;
    swap_done_d = do_swap;
    cnt_d       = cnt_q + CNT_W'(accept) - CNT_W'(sum_valid_q);
    vld_pipe_d  = {vld_pipe_q[STAGES-2:0], accept};
    sum_valid_d = vld_pipe_q[STAGES-1];
    sum_d       = vld_pipe_q[STAGES-1] ? ds_out : sum_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ld_q        <= EMPTY;
      beat_q      <= '0;
      pend_q      <= 1'b0;
      bank_q      <= 1'b0;
      swap_done_q <= 1'b0;
      sum_valid_q <= 1'b0;
      cnt_q       <= '0;
      vld_pipe_q  <= '0;
      sum_q       <= '0;
    end else if (EN) begin
      ld_q        <= ld_d;
      beat_q      <= beat_d;
      pend_q      <= pend_d;
      bank_q      <= bank_d;
      swap_done_q <= swap_done_d;
      sum_valid_q <= sum_valid_d;
      cnt_q       <= cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      sum_q       <= sum_d;
    end
  end

  // row r enters the array r cycles late so its wavefront meets the psums
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [r:0][DW-1:0] sk_q, sk_d;
    always_comb begin
      sk_d[0] = act_in[r*DW +: DW];
      for (int i = 1; i <= r; i++) sk_d[i] = sk_q[i-1];
    end
    always_ff @(posedge CLK) begin
      if (RESET)   sk_q <= '0;
      else if (EN) sk_q <= sk_d;
    end
    assign a_h[r][0]        = sk_q[r];
    assign a_edge_unused[r] = a_h[r][COLS];
  end

  assign ps_v[0]       = '0;
  assign w_v[0]        = w_row;
  assign w_edge_unused = w_v[ROWS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      pe_cell #(.DW(DW), .AW(AW)) u_pe (
        .clk     (CLK),
        .rst     (RESET),
        .en      (EN),
        .bank_sel(bank_q),
        .w_shift (beat),
        .a_in    (a_h[r][c]),
        .w_in    (w_v[r][c]),
        .ps_in   (ps_v[r][c]),
        .a_out   (a_h[r][c+1]),
        .w_out   (w_v[r+1][c]),
        .ps_out  (ps_v[r+1][c])
      );
    end
  end

  // column c finishes COLS-1-c cycles before the last column; pad it to line up
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    if (c == COLS - 1) begin : g_pass
      assign ds_out[c] = ps_v[ROWS][c];
    end else begin : g_dly
      localparam int D = COLS - 1 - c;
      logic [D-1:0][AW-1:0] ds_q, ds_d;
      always_comb begin
        ds_d[0] = ps_v[ROWS][c];
        for (int i = 1; i < D; i++) ds_d[i] = ds_q[i-1];
      end
      always_ff @(posedge CLK) begin
        if (RESET)   ds_q <= '0;
        else if (EN) ds_q <= ds_d;
      end
      assign ds_out[c] = ds_q[D-1];
    end
  end

  assign w_ready   = (ld_q != FULL);
  assign act_ready = ~pend_q;
  assign swap_done = swap_done_q;
  assign sum_valid = sum_valid_q;
  assign sum_out   = sum_q;
  assign bank_sel  = bank_q;
  assign busy      = (cnt_q != '0) | pend_q;

endmodule

// File: tb/tb_systolic_array_db.sv
// Randomized + directed bench for systolic_array_db against a matrix-level reference model.
module tb_systolic_array_db;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 32;
  localparam int AW   = 64;
  localparam int LAT  = ROWS + COLS;

  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic               EN = 1'b1;
  logic               w_valid = 1'b0;
  logic               swap_req = 1'b0;
  logic               act_valid = 1'b0;
  logic [COLS*DW-1:0] w_row = '0;
  logic [ROWS*DW-1:0] act_in = '0;
  logic               w_ready, swap_done, act_ready, sum_valid, bank_sel, busy;
  logic [COLS*AW-1:0] sum_out;

  always #5 CLK = ~CLK;

  systolic_array_db #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .swap_req(swap_req), .swap_done(swap_done),
    .act_valid(act_valid), .act_ready(act_ready), .act_in(act_in),
    .sum_valid(sum_valid), .sum_out(sum_out),
    .bank_sel(bank_sel), .busy(busy)
  );

  // reference model: two weight matrices, a load count, and a list of accepted vectors
  typedef struct {
    int                 a;
    logic [COLS*AW-1:0] v;
  } exp_t;

  exp_t               q[$];
  int                 m_w[2][ROWS][COLS];
  int                 m_sel, m_pend, m_ld, m_nb, m_t, m_swap_t;
  logic [COLS*AW-1:0] m_out;
  int                 n_tests = 0;
  int                 n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    foreach (m_w[b, r, c]) m_w[b][r][c] = 0;
    m_sel = 0; m_pend = 0; m_ld = 0; m_nb = 0; m_swap_t = -1; m_out = '0;
  endtask

  function automatic logic [COLS*AW-1:0] dot(input logic [ROWS*DW-1:0] a, input int bk);
    logic [COLS*AW-1:0] v;
    longint             s;
    for (int c = 0; c < COLS; c++) begin
      s = 0;
      for (int r = 0; r < ROWS; r++)
        s += longint'($signed(a[r*DW +: DW])) * longint'(m_w[bk][r][c]);
      v[c*AW +: AW] = s;
    end
    return v;
  endfunction

  task automatic tick();
    bit   acc, beat, swp;
    logic sv_exp;
    acc = 0; beat = 0; swp = 0;
    if (!RESET && EN) begin
      acc  = act_valid && (m_pend == 0);
      beat = w_valid && (m_ld != 2);
      swp  = (m_pend != 0) && (q.size() == 0) && (m_ld == 2);
    end
    @(posedge CLK);
    if (RESET) m_reset();
    else if (EN) begin
      m_t++;
      if (acc) q.push_back('{m_t, dot(act_in, m_sel)});
      if (beat) begin
        for (int r = ROWS - 1; r > 0; r--)
          for (int c = 0; c < COLS; c++) m_w[1-m_sel][r][c] = m_w[1-m_sel][r-1][c];
        for (int c = 0; c < COLS; c++) m_w[1-m_sel][0][c] = w_row[c*DW +: DW];
        m_nb++;
        if (m_nb == ROWS) begin m_ld = 2; m_nb = 0; end
        else m_ld = 1;
      end
      if (swp) begin m_sel = 1 - m_sel; m_ld = 0; m_swap_t = m_t; end
      m_pend = swp ? 0 : ((m_pend != 0 || swap_req) ? 1 : 0);
      while (q.size() > 0 && q[0].a + LAT + 1 <= m_t) void'(q.pop_front());
      if (q.size() > 0 && q[0].a + LAT == m_t) m_out = q[0].v;
    end
    #1;
    sv_exp = (q.size() > 0 && q[0].a + LAT == m_t);
    chk("w_ready", w_ready, m_ld != 2);
    chk("act_ready", act_ready, m_pend == 0);
    chk("bank_sel", bank_sel, m_sel[0]);
    chk("swap_done", swap_done, m_swap_t == m_t);
    chk("busy", busy, q.size() != 0 || m_pend != 0);
    chk("sum_valid", sum_valid, sv_exp);
    for (int c = 0; c < COLS; c++)
      chk($sformatf("sum_out[%0d]", c), sum_out[c*AW +: AW], m_out[c*AW +: AW]);
    if (swap_done) swap_req = 1'b0;
  endtask

  function automatic logic [ROWS*DW-1:0] vec4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  task automatic send(input logic [ROWS*DW-1:0] v);
    act_valid = 1'b1; act_in = v;
    tick();
    act_valid = 1'b0;
  endtask

  // one beat carrying row r of a matrix with diag on the diagonal and off elsewhere
  task automatic beat_row(input int diag, input int off, input int r);
    w_valid = 1'b1;
    for (int c = 0; c < COLS; c++) w_row[c*DW +: DW] = (r == c) ? diag : off;
    tick();
    w_valid = 1'b0;
  endtask

  task automatic load_bank(input int diag, input int off);
    for (int r = ROWS - 1; r >= 0; r--) beat_row(diag, off, r);
  endtask

  task automatic do_swap();
    bit seen;
    seen = 0;
    swap_req = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (swap_done) seen = 1;
    end
    chk("swap_seen", seen, 1);
    swap_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && busy; i++) tick();
    chk("drain_busy", busy, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m_t = 0;
    m_reset();
    RESET = 1'b1;
    idle(2);
    RESET = 1'b0;

    // no weights loaded yet: all-zero result
    send(vec4(1, 2, 3, 4));
    idle(10);

    // identity
    load_bank(1, 0);
    do_swap();
    send(vec4(1, 2, 3, 4));
    idle(10);

    // signed products and wide accumulation
    load_bank(3, 3);
    do_swap();
    send(vec4(-1, -1, -1, -1));
    load_bank(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    drain();
    do_swap();
    send(vec4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF));
    drain();

    // back-to-back vectors
    for (int i = 0; i < 4; i++) send({$urandom, $urandom, $urandom, $urandom});
    drain();

    // load 2*I while streaming, request the swap with the shadow half loaded
    act_valid = 1'b1;
    act_in = vec4(5, -6, 7, -8);
    beat_row(2, 0, 3);
    act_in = vec4(9, 10, -11, 12);
    beat_row(2, 0, 2);
    swap_req = 1'b1;
    idle(3);
    act_valid = 1'b0;
    idle(12);
    beat_row(2, 0, 1);
    beat_row(2, 0, 0);
    do_swap();
    send(vec4(1, 2, 3, 4));
    idle(2);

    // freeze mid-stream
    send(vec4(3, 1, 4, 1));
    idle(3);
    EN = 1'b0;
    idle(3);
    EN = 1'b1;
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      EN        = ($urandom % 10) != 0;
      act_valid = $urandom % 2;
      for (int r = 0; r < ROWS; r++)
        act_in[r*DW +: DW] = ($urandom % 2) ? $urandom : ($urandom_range(0, 15) - 8);
      w_valid = ($urandom % 3) == 0;
      for (int c = 0; c < COLS; c++)
        w_row[c*DW +: DW] = ($urandom % 2) ? $urandom : ($urandom_range(0, 15) - 8);
      if (!swap_req && ($urandom % 25) == 0) swap_req = 1'b1;
      tick();
    end
    EN = 1'b1; act_valid = 1'b0; w_valid = 1'b0; swap_req = 1'b0;
    idle(20);

    // reset mid-stream discards in-flight work and clears both banks
    load_bank(7, 1);
    do_swap();
    for (int i = 0; i < 3; i++) send({$urandom, $urandom, $urandom, $urandom});
    idle(2);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    idle(12);
    send(vec4(1, 2, 3, 4));
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
